// File: rtl/fp_mul_pipe_if.sv
// fp_mul_pipe_if: operand and result handshake bundle for fp_mul_pipe.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; a producer holds valid and its payload stable until that edge.
interface fp_mul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    // The multiplier itself.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage IEEE-754 multiplier with round-to-nearest-even,
// DAZ/FTZ, full special-case handling and {invalid, overflow, underflow,
// inexact} flags. Optional macro FP_MUL_STICKY_FLAGS_EN adds flags_clr and
// sticky_flags (accumulated flags of every delivered result).
// Stages: S1 unpack/classify/exponent sum, S2 mantissa multiply,
// S3 normalise/round/pack. One global enable moves every stage together.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FP_MUL_STICKY_FLAGS_EN
    input  logic        flags_clr,
    output logic [3:0]  sticky_flags,
`endif
    fp_mul_pipe_if.slave bus
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int EW = EXP_W + 2;       // signed working exponent width
    localparam int PW = 2 * MAN_W + 2;   // full mantissa product width

    localparam logic [EXP_W-1:0]    EXP_ONES = '1;
    localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    logic adv;

    // ---------------- S1: unpack and classify ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

    assign {sa, ea, fa} = bus.a;
    assign {sb, eb, fb} = bus.b;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_snan = a_nan && !fa[MAN_W-1];
    assign b_snan = b_nan && !fb[MAN_W-1];

    logic                   s1_sign_d, s1_spec_d;
    logic signed [EW-1:0]   s1_exp_d;
    logic [W-1:0]           s1_sres_d;
    logic [3:0]             s1_sflg_d;

    logic                   s1_valid_q, s1_sign_q, s1_spec_q;
    logic signed [EW-1:0]   s1_exp_q;
    logic [MAN_W:0]         s1_ma_q, s1_mb_q;
    logic [W-1:0]           s1_sres_q;
    logic [3:0]             s1_sflg_q;

    // Exponent sum and special-case override decided before the multiply.
    always_comb begin
        s1_sign_d = sa ^ sb;
        s1_exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
        s1_spec_d = 1'b1;
        s1_sres_d = '0;
        s1_sflg_d = '0;
        if (a_nan || b_nan) begin
            s1_sres_d = QNAN;
            s1_sflg_d = {a_snan || b_snan, 3'b000};
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            s1_sres_d = QNAN;
            s1_sflg_d = 4'b1000;
        end else if (a_inf || b_inf) begin
            s1_sres_d = {s1_sign_d, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero) begin
            s1_sres_d = {s1_sign_d, {(W-1){1'b0}}};
        end else begin
            s1_spec_d = 1'b0;
        end
    end

    // S1 register: capture classified operands when the pipe advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= bus.in_valid;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_ma_q    <= {1'b1, fa};
            s1_mb_q    <= {1'b1, fb};
            s1_spec_q  <= s1_spec_d;
            s1_sres_q  <= s1_sres_d;
            s1_sflg_q  <= s1_sflg_d;
        end
    end

    // ---------------- S2: mantissa multiply ----------------
    logic [PW-1:0]          prod_d;
    logic                   s2_valid_q, s2_sign_q, s2_spec_q;
    logic signed [EW-1:0]   s2_exp_q;
    logic [PW-1:0]          s2_prod_q;
    logic [W-1:0]           s2_sres_q;
    logic [3:0]             s2_sflg_q;

    assign prod_d = {{(MAN_W+1){1'b0}}, s1_ma_q} * {{(MAN_W+1){1'b0}}, s1_mb_q};

    // S2 register: full-width product plus pass-through of S1 results.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_exp_q   <= s1_exp_q;
            s2_prod_q  <= prod_d;
            s2_spec_q  <= s1_spec_q;
            s2_sres_q  <= s1_sres_q;
            s2_sflg_q  <= s1_sflg_q;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic                 p_msb, guard_b, round_b, sticky_b, round_up;
    logic [MAN_W-1:0]     frac;
    logic [MAN_W:0]       frac_r;
    logic signed [EW-1:0] exp_f;
    logic [W-1:0]         res_d;
    logic [3:0]           flg_d;

    // Product lies in [1,4); a set MSB means one extra bit of integer part.
    assign p_msb    = s2_prod_q[PW-1];
    assign frac     = p_msb ? s2_prod_q[PW-2 -: MAN_W] : s2_prod_q[PW-3 -: MAN_W];
    assign guard_b  = p_msb ? s2_prod_q[MAN_W]   : s2_prod_q[MAN_W-1];
    assign round_b  = p_msb ? s2_prod_q[MAN_W-1] : s2_prod_q[MAN_W-2];
    assign sticky_b = p_msb ? |s2_prod_q[MAN_W-2:0] : |s2_prod_q[MAN_W-3:0];
    assign round_up = guard_b && (round_b || sticky_b || frac[0]);
    // A carry out of the fraction leaves it all-zero, so only the exponent moves.
    assign frac_r   = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    assign exp_f    = s2_exp_q + $signed({{(EW-1){1'b0}}, p_msb})
                               + $signed({{(EW-1){1'b0}}, frac_r[MAN_W]});

    // Final result selection: specials, then overflow, underflow, normal.
    always_comb begin
        res_d = '0;
        flg_d = '0;
        if (s2_spec_q) begin
            res_d = s2_sres_q;
            flg_d = s2_sflg_q;
        end else if (exp_f >= EXP_MAX) begin
            res_d = {s2_sign_q, EXP_ONES, {MAN_W{1'b0}}};
            flg_d = 4'b0101;
        end else if (exp_f <= EXP_ZERO) begin
            res_d = {s2_sign_q, {(W-1){1'b0}}};
            flg_d = 4'b0011;
        end else begin
            res_d = {s2_sign_q, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
            flg_d = {3'b000, guard_b | round_b | sticky_b};
        end
    end

    logic         out_valid_q;
    logic [W-1:0] result_q;
    logic [3:0]   flags_q;

    // Output register: holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (adv) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                result_q <= res_d;
                flags_q  <= flg_d;
            end
        end
    end

    // Whole pipe moves when the output slot is free or being drained.
    assign adv           = bus.out_ready || !out_valid_q;
    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

`ifdef FP_MUL_STICKY_FLAGS_EN
    logic [3:0] sticky_q;

    // Accumulate flags of delivered results; clear has priority.
    always_ff @(posedge clk) begin
        if (rst || flags_clr) begin
            sticky_q <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            sticky_q <= sticky_q | flags_q;
        end
    end

    assign sticky_flags = sticky_q;
`endif
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed and back-pressured stimulus for fp_mul_pipe (FP32
// instance plus an FP16 instance). An integer/remainder reference model
// predicts every delivered result; directed vectors also carry literals.
module tb_fp_mul_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc_cyc = 0;
    int   last_tries = 0;
    bit   bp_mode = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fp_mul_pipe_if #(.EXP_W(8), .MAN_W(23)) bus();
    fp_mul_pipe_if #(.EXP_W(5), .MAN_W(10)) bus16();

`ifdef FP_MUL_STICKY_FLAGS_EN
    logic       flags_clr = 1'b0;
    logic [3:0] sticky_flags;
    logic       flags_clr16 = 1'b0;
    logic [3:0] sticky_flags16;
`endif

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef FP_MUL_STICKY_FLAGS_EN
        .flags_clr    (flags_clr),
        .sticky_flags (sticky_flags),
`endif
        .bus          (bus)
    );

    fp_mul_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk          (clk),
        .rst          (rst),
`ifdef FP_MUL_STICKY_FLAGS_EN
        .flags_clr    (flags_clr16),
        .sticky_flags (sticky_flags16),
`endif
        .bus          (bus16)
    );

    // ---------------- reference model ----------------
    // Returns {flags[3:0], result[31:0]} for any exponent/fraction split.
    function automatic logic [35:0] fp_model(input int ew, input int mw,
                                             input logic [31:0] a, input logic [31:0] b);
        longint emax, bias, ea, eb, fa, fb, prod, q, rem, half, e, qnan, inf_v, zero_v;
        int     sh;
        logic   s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, inexact;
        logic [31:0] r;
        emax   = (longint'(1) << ew) - 1;
        bias   = (longint'(1) << (ew - 1)) - 1;
        ea     = (longint'(a) >> mw) & emax;
        eb     = (longint'(b) >> mw) & emax;
        fa     = longint'(a) & ((longint'(1) << mw) - 1);
        fb     = longint'(b) & ((longint'(1) << mw) - 1);
        s      = a[ew+mw] ^ b[ew+mw];
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        a_inf  = (ea == emax) && (fa == 0);
        b_inf  = (eb == emax) && (fb == 0);
        a_nan  = (ea == emax) && (fa != 0);
        b_nan  = (eb == emax) && (fb != 0);
        a_snan = a_nan && (((fa >> (mw - 1)) & 1) == 0);
        b_snan = b_nan && (((fb >> (mw - 1)) & 1) == 0);
        qnan   = (emax << mw) | (longint'(1) << (mw - 1));
        inf_v  = (longint'(s) << (ew + mw)) | (emax << mw);
        zero_v = longint'(s) << (ew + mw);
        if (a_nan || b_nan) begin
            r = 32'(qnan);
            return {a_snan || b_snan, 3'b000, r};
        end
        if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            r = 32'(qnan);
            return {4'b1000, r};
        end
        if (a_inf || b_inf) begin
            r = 32'(inf_v);
            return {4'b0000, r};
        end
        if (a_zero || b_zero) begin
            r = 32'(zero_v);
            return {4'b0000, r};
        end
        prod = (fa | (longint'(1) << mw)) * (fb | (longint'(1) << mw));
        e    = ea + eb - bias;
        if (prod >= (longint'(1) << (2 * mw + 1))) begin
            sh = mw + 1;
            e  = e + 1;
        end else begin
            sh = mw;
        end
        q       = prod >> sh;
        rem     = prod & ((longint'(1) << sh) - 1);
        half    = longint'(1) << (sh - 1);
        inexact = (rem != 0);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (longint'(2) << mw)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= emax) begin
            r = 32'(inf_v);
            return {4'b0101, r};
        end
        if (e <= 0) begin
            r = 32'(zero_v);
            return {4'b0011, r};
        end
        r = 32'(zero_v | (e << mw) | (q & ((longint'(1) << mw) - 1)));
        return {3'b000, inexact, r};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    logic [35:0] exp_q[$];
    bit          stalled = 1'b0;
    logic [31:0] held_r;
    logic [3:0]  held_f;

    always @(negedge clk) begin
        logic [35:0] e;
        cyc++;
        if (rst) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (!bus.out_valid || bus.result !== held_r || bus.flags !== held_f) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b r=%h f=%b, expected v=1 r=%h f=%b",
                             bus.out_valid, bus.result, bus.flags, held_r, held_f);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got r=%h f=%b, expected no result",
                             bus.result, bus.flags);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.flags, bus.result} !== e) begin
                        errors++;
                        $display("FAIL scoreboard: got f=%b r=%h, expected f=%b r=%h",
                                 bus.flags, bus.result, e[35:32], e[31:0]);
                    end
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            held_r  = bus.result;
            held_f  = bus.flags;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(fp_model(8, 23, bus.a, bus.b));
                last_acc_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drive(input logic [31:0] av, input logic [31:0] bv);
        bit acc = 1'b0;
        int tries = 0;
        bus.a = av;
        bus.b = bv;
        bus.in_valid = 1'b1;
        while (!acc && tries < 64) begin
            if (bp_mode) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        bus.in_valid = 1'b0;
        last_tries = tries;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept: in_ready stayed 0 for %0d cycles, expected 1", tries);
        end
    endtask

    task automatic run_vec(input string name, input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] er, input logic [3:0] ef);
        bit seen = 1'b0;
        int n = 0;
        int lat;
        bus.out_ready = 1'b1;
        drive(av, bv);
        while (!seen && n < 10) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.out_valid) seen = 1'b1;
        end
        lat = seen ? (cyc - last_acc_cyc) : -1;
        chk({name, "_latency"}, 64'(lat), 64'd3);
        chk({name, "_result"}, 64'(bus.result), 64'(er));
        chk({name, "_flags"}, 64'(bus.flags), 64'(ef));
        @(posedge clk);
        #1;
    endtask

    task automatic run16(input string name, input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] er, input logic [3:0] ef);
        bit seen = 1'b0;
        int n = 0;
        logic [35:0] m;
        bus16.a = av;
        bus16.b = bv;
        bus16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus16.in_valid = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            #1;
            n++;
            if (bus16.out_valid) seen = 1'b1;
        end
        m = fp_model(5, 10, {16'h0, av}, {16'h0, bv});
        chk({name, "_latency"}, 64'(seen ? n : -1), 64'd3);
        chk({name, "_result"}, 64'(bus16.result), 64'(er));
        chk({name, "_flags"}, 64'(bus16.flags), 64'(ef));
        chk({name, "_model"}, 64'({bus16.flags, bus16.result}), 64'({m[35:32], m[15:0]}));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        bp_mode = 1'b0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.in_valid    = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.out_ready   = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", 64'(bus.result), 64'd0);
        chk("rst_flags", 64'(bus.flags), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // FP32 directed vectors with hand-computed results
        run_vec("mul_1p5x2",  32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        run_vec("rne_sticky", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        run_vec("rne_3x3",    32'h3F800003, 32'h3F800003, 32'h3F800006, 4'b0001);
        run_vec("tie_odd",    32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001);
        run_vec("tie_even",   32'h3FC00000, 32'h3F800003, 32'h3FC00004, 4'b0001);
        run_vec("rnd_carry",  32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'b0001);
        run_vec("neg",        32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
        run_vec("max_norm",   32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000);
        run_vec("min_norm",   32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000);
        run_vec("ovf",        32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
        run_vec("ovf_norm",   32'h7F7FFFFF, 32'h3F800001, 32'h7F800000, 4'b0101);
        run_vec("ovf_round",  32'h7F7FFFFE, 32'h3F800001, 32'h7F800000, 4'b0101);
        run_vec("unf",        32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011);
        run_vec("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        run_vec("ninf_x_2",   32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
        run_vec("inf_x_ninf", 32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0000);
        run_vec("snan",       32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);
        run_vec("qnan",       32'h7FC00000, 32'h40000000, 32'h7FC00000, 4'b0000);
        run_vec("neg_zero",   32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
        run_vec("daz",        32'h00000001, 32'hBF800000, 32'h80000000, 4'b0000);

        // FP16 instance
        run16("h_1p5x2",   16'h3E00, 16'h4000, 16'h4200, 4'b0000);
        run16("h_inf_x_0", 16'h7C00, 16'h0000, 16'h7E00, 4'b1000);
        run16("h_ovf",     16'h7BFF, 16'h4000, 16'h7C00, 4'b0101);

        // Full-rate burst: every operand accepted on its first cycle
        for (int i = 0; i < 4; i++) begin
            drive(32'h3F800000 + 32'(i * 32'h00100001), 32'h40000000 + 32'(i));
            chk("burst_accept", 64'(last_tries), 64'd1);
        end
        drain();

        // Random operands under pseudo-random back-pressure
        bp_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive($urandom, $urandom);
        end
        drain();

        // Reset after two accepts: nothing may emerge afterwards
        drive(32'h3FC00000, 32'h40000000);
        drive(32'h40400000, 32'h40400000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

`ifdef FP_MUL_STICKY_FLAGS_EN
        flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
        chk("sticky_clr0", 64'(sticky_flags), 64'd0);
        run_vec("s_ovf",   32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101);
        chk("sticky_ovf", 64'(sticky_flags), 64'b0101);
        run_vec("s_inv",   32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
        chk("sticky_inv", 64'(sticky_flags), 64'b1101);
        run_vec("s_exact", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        chk("sticky_hold", 64'(sticky_flags), 64'b1101);
        flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
        chk("sticky_clr1", 64'(sticky_flags), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
